// File: rtl/filter_serializer_pkg.sv
// Shared types for the filter_serializer block: FSM state encoding and width limit.
package filter_serializer_pkg;

    localparam int DATA_W_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY
    } state_e;

endpackage

// File: rtl/filter_serializer_if.sv
// Word handshake and serial output bundle between the decimation filter and the serializer.
interface filter_serializer_if #(
    parameter int DATA_W = 12
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              msb_first;
    logic              bit_tick;
    logic              sdo;
    logic              frame;
    logic              done;

    modport master (
        output in_valid, in_data, msb_first, bit_tick,
        input  in_ready, sdo, frame, done
    );

    modport slave (
        input  in_valid, in_data, msb_first, bit_tick,
        output in_ready, sdo, frame, done
    );
endinterface

// File: rtl/filter_serializer_hold.sv
// One-entry holding register in front of the shifter; ready depends only on the registered flag.
module filter_serializer_hold #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              drain_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_v_q, hold_v_d;

    assign ready_o = rst_n && !hold_v_q;
    assign data_o  = hold_q;
    assign valid_o = hold_v_q;

    always_comb begin
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        if (drain_i) begin
            hold_v_d = 1'b0;
        end
        // An accept lands after any drain in the same cycle, so the new word is never lost.
        if (valid_i && ready_o) begin
            hold_d   = data_i;
            hold_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
        end
    end
endmodule

// File: rtl/filter_serializer.sv
// Word-to-bit serializer with holding register, selectable bit order and frame strobe.
// Optional trailing even-parity bit when FILTER_SERIALIZER_PARITY_EN is defined.
module filter_serializer
    import filter_serializer_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    filter_serializer_if.slave   bus
);
    if (DATA_W < 2 || DATA_W > DATA_W_MAX) begin : g_bad_width
        $error("filter_serializer: DATA_W out of range");
    end

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              ord_q, ord_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sdo_q, sdo_d;
    logic              frame_q, frame_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] hold_data;
    logic              hold_v;
    logic              reload;
`ifdef FILTER_SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    filter_serializer_hold #(.DATA_W(DATA_W)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (bus.in_valid),
        .data_i  (bus.in_data),
        .drain_i (reload),
        .ready_o (bus.in_ready),
        .data_o  (hold_data),
        .valid_o (hold_v)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        ord_d   = ord_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        reload  = 1'b0;
`ifdef FILTER_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                reload = hold_v;
            end
            ST_SHIFT: begin
                if (bus.bit_tick) begin
                    sh_d  = ord_q ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef FILTER_SERIALIZER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        done_d  = 1'b1;
                        reload  = hold_v;
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_PARITY: begin
`ifdef FILTER_SERIALIZER_PARITY_EN
                if (bus.bit_tick) begin
                    done_d  = 1'b1;
                    reload  = hold_v;
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (reload) begin
            sh_d    = hold_data;
            ord_d   = bus.msb_first;
            cnt_d   = '0;
            state_d = ST_SHIFT;
`ifdef FILTER_SERIALIZER_PARITY_EN
            par_d   = ^hold_data;
`endif
        end

        // Outputs are derived from next-state values so they can be registered without a cycle of lag.
        frame_d = (state_d != ST_IDLE);
        case (state_d)
            ST_SHIFT:  sdo_d = ord_d ? sh_d[DATA_W-1] : sh_d[0];
`ifdef FILTER_SERIALIZER_PARITY_EN
            ST_PARITY: sdo_d = par_d;
`endif
            default:   sdo_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            ord_q   <= 1'b0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef FILTER_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            frame_q <= frame_d;
            done_q  <= done_d;
`ifdef FILTER_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.sdo   = sdo_q;
    assign bus.frame = frame_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_filter_serializer.sv
// Self-checking bench for filter_serializer: directed cases plus randomized traffic against a queue model.
module tb_filter_serializer;
    localparam int DW = 12;
`ifdef FILTER_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WLEN = DW + PAR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    filter_serializer_if #(.DATA_W(DW)) bus ();

    filter_serializer #(.DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: accepted-but-unloaded words, and the bits still owed for the word on the line.
    logic [DW-1:0] pend[$];
    logic          exp_bits[$];
    bit            busy     = 1'b0;
    bit            done_exp = 1'b0;

    // Observations: bits retired on ticks while frame is high, done pulses.
    logic obs[$];
    int   n_done   = 0;
    int   n_fticks = 0;
    int   done_at[$];

    bit tick_en  = 1'b1;
    int tper     = 2;
    int tph      = 0;
    bit rand_ord = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs_v === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic void load_word(input logic [DW-1:0] w, input logic ord);
        for (int i = 0; i < DW; i++) begin
            exp_bits.push_back(ord ? w[DW-1-i] : w[i]);
        end
        if (PAR != 0) exp_bits.push_back(^w);
        busy = 1'b1;
    endfunction

    function automatic logic [DW-1:0] pack(input int base);
        logic [DW-1:0] r;
        r = 'x;
        for (int i = 0; i < DW; i++) begin
            if (base + i < obs.size()) r[DW-1-i] = obs[base + i];
        end
        return r;
    endfunction

    task automatic clr();
        obs.delete();
        done_at.delete();
        n_done   = 0;
        n_fticks = 0;
    endtask

    // One clock cycle: drive, check against the model, advance the model, cross the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d);
        logic tk;
        bit   acc;
        tk = tick_en && ((tper == 0) ? ($urandom_range(1, 0) == 1) : ((tph % tper) == (tper - 1)));
        tph++;
        if (rand_ord) bus.msb_first = $urandom_range(1, 0) == 1;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.bit_tick = tk;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(rst_n && pend.size() == 0));
        chk("frame",    32'(bus.frame),    32'(busy));
        chk("sdo",      32'(bus.sdo),      32'(busy ? exp_bits[0] : 1'b0));
        chk("done",     32'(bus.done),     32'(done_exp));
        if (bus.done) begin
            n_done++;
            done_at.push_back(n_fticks);
        end
        if (tk && bus.frame) begin
            obs.push_back(bus.sdo);
            n_fticks++;
        end

        acc      = v && rst_n && pend.size() == 0;
        done_exp = 1'b0;
        if (!rst_n) begin
            pend.delete();
            exp_bits.delete();
            busy = 1'b0;
        end else begin
            if (busy && tk) begin
                void'(exp_bits.pop_front());
                if (exp_bits.size() == 0) begin
                    done_exp = 1'b1;
                    busy     = 1'b0;
                end
            end
            if (!busy && pend.size() > 0) load_word(pend.pop_front(), bus.msb_first);
            if (acc) pend.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0);
    endtask

    task automatic offer(input logic [DW-1:0] d, output int tries);
        bit acc;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 500) begin
            acc = rst_n && pend.size() == 0;
            cyc(1'b1, d);
            tries++;
        end
        if (!acc) chk("offer_timeout", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || pend.size() > 0) && n < 5000) begin
            cyc(1'b0, '0);
            n++;
        end
        chk("drain_timeout", 32'(busy || pend.size() > 0), 32'd0);
        cyc(1'b0, '0);
    endtask

    task automatic wait_bits(input int nb);
        int n;
        n = 0;
        while (obs.size() < nb && n < 500) begin
            cyc(1'b0, '0);
            n++;
        end
        chk("wait_bits_timeout", 32'(obs.size() >= nb), 32'd1);
    endtask

    initial begin
        int            tries;
        logic          s0;
        int            nb0;
        logic [DW-1:0] w;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.msb_first = 1'b1;
        bus.bit_tick  = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("por_sdo",      32'(bus.sdo),      32'd0);
        chk("por_frame",    32'(bus.frame),    32'd0);
        chk("por_done",     32'(bus.done),     32'd0);
        chk("por_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("por_release_ready", 32'(bus.in_ready), 32'd1);

        // Single word, MSB first, tick every 2 cycles.
        clr();
        tper = 2;
        bus.msb_first = 1'b1;
        offer(12'h001, tries);
        drain();
        chk("single_bits",  32'(pack(0)),     32'h001);
        chk("single_ticks", 32'(n_fticks),    32'(WLEN));
        chk("single_done",  32'(n_done),      32'd1);

        // LSB first: expected line sequence 0,0,1,1,1,0,1,0,0,1,0,1.
        clr();
        bus.msb_first = 1'b0;
        offer(12'hA5C, tries);
        drain();
        chk("lsb_seq",  32'(pack(0)), 32'h3A5);
        chk("lsb_done", 32'(n_done),  32'd1);

        // Back-to-back words: second is held while the first shifts.
        clr();
        bus.msb_first = 1'b1;
        offer(12'hFFF, tries);
        offer(12'h000, tries);
        chk("b2b_held", 32'(tries > 1), 32'd1);
        drain();
        chk("b2b_word0", 32'(pack(0)),    32'hFFF);
        chk("b2b_word1", 32'(pack(WLEN)), 32'h000);
        chk("b2b_ticks", 32'(n_fticks),   32'(2 * WLEN));
        chk("b2b_done",  32'(n_done),     32'd2);
        if (done_at.size() == 2) chk("b2b_spacing", 32'(done_at[1] - done_at[0]), 32'(WLEN));
        else                     chk("b2b_done_at", 32'(done_at.size()), 32'd2);

        // Tick stall mid-word.
        clr();
        tper = 1;
        w = DW'($urandom);
        offer(w, tries);
        wait_bits(5);
        s0  = bus.sdo;
        nb0 = obs.size();
        tick_en = 1'b0;
        run(20);
        chk("stall_sdo",  32'(bus.sdo),    32'(s0));
        chk("stall_bits", 32'(obs.size()), 32'(nb0));
        tick_en = 1'b1;
        drain();
        chk("stall_word", 32'(pack(0)), 32'(w));
        chk("stall_done", 32'(n_done),  32'd1);

`ifdef FILTER_SERIALIZER_PARITY_EN
        clr();
        tper = 2;
        bus.msb_first = 1'b1;
        offer(12'h007, tries);
        drain();
        chk("par_word",  32'(pack(0)),      32'h007);
        chk("par_nbits", 32'(obs.size()),   32'd13);
        if (obs.size() == 13) chk("par_bit", 32'(obs[12]), 32'd1);
        chk("par_done",  32'(n_done),       32'd1);
`endif

        // Reset in the middle of a word with another word held.
        clr();
        tper = 2;
        offer(12'h5A3, tries);
        offer(12'h3C6, tries);
        wait_bits(4);
        rst_n = 1'b0;
        run(3);
        chk("rst_sdo",   32'(bus.sdo),      32'd0);
        chk("rst_frame", 32'(bus.frame),    32'd0);
        chk("rst_done",  32'(bus.done),     32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(bus.in_ready), 32'd1);
        run(40);
        chk("rst_no_done", 32'(n_done), 32'd0);

        // Randomized traffic: random data, ticks, gaps and bit order changing every cycle.
        clr();
        tper     = 0;
        rand_ord = 1'b1;
        for (int k = 0; k < 30; k++) begin
            offer(DW'($urandom), tries);
            run($urandom_range(3, 0));
        end
        drain();
        rand_ord = 1'b0;
        chk("rand_done",  32'(n_done),     32'd30);
        chk("rand_nbits", 32'(obs.size()), 32'(30 * WLEN));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
